// File: rtl/pc_register_unit.sv
// Program-counter register unit for the multicycle MIPS datapath.
// Holds PC, EPC and a sticky misaligned-fetch fault with its offending address.
module pc_register_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic        CHECK_ALIGN  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_next,
  input  logic        pc_write,
  input  logic        pc_write_cond,
  input  logic [1:0]  branch_op,
  input  logic        alu_zero,
  input  logic        alu_neg,
  input  logic        epc_write,
  input  logic [31:0] epc_in,
  input  logic        fault_ack,
  output logic [31:0] pc,
  output logic [31:0] epc,
  output logic        branch_taken,
  output logic        pc_loaded,
  output logic        fault_pending,
  output logic [31:0] fault_addr
);

  typedef enum logic {S_IDLE, S_FAULT} fault_state_e;

  fault_state_e state_q;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  epc_q, epc_d;
  logic         pc_loaded_q, pc_loaded_d;
  logic         fault_pending_q;
  logic [31:0]  fault_addr_q;
  logic         cond, load_req, misaligned, new_fault;

  // Branch condition from the ALU flags; zero/neg describe the compare result.
  always_comb begin
    cond = 1'b0;
    unique case (branch_op)
      2'b00: cond = alu_zero;
      2'b01: cond = ~alu_zero;
      2'b10: cond = alu_zero | alu_neg;
      2'b11: cond = ~alu_zero & ~alu_neg;
    endcase
  end

  // Load decision and next-state for PC, EPC and the load pulse.
  always_comb begin
    branch_taken = pc_write_cond & cond;
    load_req     = pc_write | branch_taken;
    misaligned   = CHECK_ALIGN & (pc_next[1:0] != 2'b00);
    new_fault    = load_req & misaligned;
    pc_loaded_d  = load_req & ~misaligned;
    pc_d         = pc_loaded_d ? pc_next : pc_q;
    epc_d        = epc_write ? epc_in : epc_q;
  end

  // PC / EPC / load-pulse registers; a misaligned target leaves PC untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q        <= RESET_VECTOR;
      epc_q       <= '0;
      pc_loaded_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      epc_q       <= epc_d;
      pc_loaded_q <= pc_loaded_d;
    end
  end

  // Fault FSM: a new fault always wins over an ack in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= S_IDLE;
      fault_pending_q <= 1'b0;
      fault_addr_q    <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (new_fault) begin
            state_q         <= S_FAULT;
            fault_pending_q <= 1'b1;
            fault_addr_q    <= pc_next;
          end
        end
        S_FAULT: begin
          if (new_fault) begin
            fault_addr_q <= pc_next;
          end else if (fault_ack) begin
            state_q         <= S_IDLE;
            fault_pending_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign pc            = pc_q;
  assign epc           = epc_q;
  assign pc_loaded     = pc_loaded_q;
  assign fault_pending = fault_pending_q;
  assign fault_addr    = fault_addr_q;

endmodule
